// File: rtl/bitsync_dac_pkg.sv
// Shared constants and types for the bitsync test-DAC output mux.
package bitsync_dac_pkg;

    localparam int unsigned SEL_W   = 4;
    localparam int unsigned CHSEL_W = 3;
    localparam int unsigned BLANK_W = 4;

    typedef enum logic [SEL_W-1:0] {
        SRC_DF   = 4'd0,
        SRC_SYM  = 4'd1,
        SRC_AGC  = 4'd2,
        SRC_LOCK = 4'd3,
        SRC_RAMP = 4'd4
    } src_e;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_BLANK  = 2'd1,
        ST_FROZEN = 2'd2
    } state_e;

    // Unused select codes fall back to the decimating-filter source.
    function automatic src_e decode_src(input logic [SEL_W-1:0] sel);
        src_e src;
        case (sel)
            4'd1:    src = SRC_SYM;
            4'd2:    src = SRC_AGC;
            4'd3:    src = SRC_LOCK;
            4'd4:    src = SRC_RAMP;
            default: src = SRC_DF;
        endcase
        return src;
    endfunction

endpackage

// File: rtl/bitsync_dac_mux_n_if.sv
// Bus between the bitsync channels / DAC controls and the DAC output mux.
interface bitsync_dac_mux_n_if
    import bitsync_dac_pkg::*;
#(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned NUM_DAC = 3,
    parameter int unsigned DATA_W  = 18,
    parameter int unsigned AGC_W   = 21,
    parameter int unsigned LOCK_W  = 16
);

    logic [NUM_CH*DATA_W-1:0]   dfData;
    logic [NUM_CH-1:0]          dfClkEn;
    logic [NUM_CH*DATA_W-1:0]   symData;
    logic [NUM_CH-1:0]          sym2xEn;
    logic [NUM_CH-1:0]          symEn;
    logic [NUM_CH*AGC_W-1:0]    agcGain;
    logic [NUM_CH*LOCK_W-1:0]   lockCounter;
    logic [NUM_DAC*SEL_W-1:0]   dacSelect;
    logic [NUM_DAC*CHSEL_W-1:0] dacChSel;
    logic [NUM_DAC-1:0]         dacFreeze;
    logic [NUM_DAC-1:0]         dacClkEn;
    logic [NUM_DAC*DATA_W-1:0]  dacData;

    modport slave (
        input  dfData, dfClkEn, symData, sym2xEn, symEn, agcGain, lockCounter,
        input  dacSelect, dacChSel, dacFreeze,
        output dacClkEn, dacData
    );

    modport master (
        output dfData, dfClkEn, symData, sym2xEn, symEn, agcGain, lockCounter,
        output dacSelect, dacChSel, dacFreeze,
        input  dacClkEn, dacData
    );

endinterface

// File: rtl/bitsync_dac_lane.sv
// One DAC output: channel/source mux, blank/freeze state machine and ramp generator.
module bitsync_dac_lane
    import bitsync_dac_pkg::*;
#(
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned DATA_W       = 18,
    parameter int unsigned LOCK_W       = 16,
    parameter int unsigned BLANK_CYCLES = 4,
    parameter int unsigned RAMP_STEP    = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CH*DATA_W-1:0]   df_data,
    input  logic [NUM_CH-1:0]          df_en,
    input  logic [NUM_CH*DATA_W-1:0]   sym_data,
    input  logic [NUM_CH-1:0]          sym2x_en,
    input  logic [NUM_CH-1:0]          sym_en,
    input  logic [NUM_CH*DATA_W-1:0]   agc_data,
    input  logic [NUM_CH*LOCK_W-1:0]   lock_cnt,
    input  logic [SEL_W-1:0]           sel,
    input  logic [CHSEL_W-1:0]         ch_sel,
    input  logic                       freeze,
    output logic                       clk_en,
    output logic [DATA_W-1:0]          data
);

    localparam logic [BLANK_W-1:0] BLANK_RELOAD = BLANK_W'(BLANK_CYCLES - 1);
    localparam logic [DATA_W-1:0]  STEP         = DATA_W'(RAMP_STEP);
    localparam int unsigned        PAD_W        = DATA_W - LOCK_W;

    state_e              state;
    logic [BLANK_W-1:0]  blank_cnt;
    logic [DATA_W-1:0]   ramp_cnt;
    logic [SEL_W-1:0]    prev_sel;
    logic [CHSEL_W-1:0]  prev_ch;
    logic                pending;

    src_e                src;
    logic                changed;
    logic [DATA_W-1:0]   ch_df, ch_sym, ch_agc, ch_lock, live_data;
    logic                ch_df_en, ch_sym2x_en, ch_sym_en, live_en;

    // Channel pick; indices beyond NUM_CH-1 stay on channel 0.
    always_comb begin
        ch_df       = df_data[DATA_W-1:0];
        ch_sym      = sym_data[DATA_W-1:0];
        ch_agc      = agc_data[DATA_W-1:0];
        ch_lock     = DATA_W'(lock_cnt[LOCK_W-1:0]) << PAD_W;
        ch_df_en    = df_en[0];
        ch_sym2x_en = sym2x_en[0];
        ch_sym_en   = sym_en[0];
        for (int i = 1; i < int'(NUM_CH); i++) begin
            if (ch_sel == CHSEL_W'(i)) begin
                ch_df       = df_data[i*DATA_W +: DATA_W];
                ch_sym      = sym_data[i*DATA_W +: DATA_W];
                ch_agc      = agc_data[i*DATA_W +: DATA_W];
                ch_lock     = DATA_W'(lock_cnt[i*LOCK_W +: LOCK_W]) << PAD_W;
                ch_df_en    = df_en[i];
                ch_sym2x_en = sym2x_en[i];
                ch_sym_en   = sym_en[i];
            end
        end
    end

    always_comb begin
        src       = decode_src(sel);
        changed   = (sel != prev_sel) || (ch_sel != prev_ch);
        live_data = ch_df;
        live_en   = ch_df_en;
        case (src)
            SRC_SYM:  begin live_data = ch_sym;   live_en = ch_sym2x_en; end
            SRC_AGC:  begin live_data = ch_agc;   live_en = ch_sym_en;   end
            SRC_LOCK: begin live_data = ch_lock;  live_en = 1'b1;        end
            SRC_RAMP: begin live_data = ramp_cnt; live_en = ch_sym_en;   end
            default:  begin live_data = ch_df;    live_en = ch_df_en;    end
        endcase
    end

    // Outputs are loaded according to the state being entered, so the first
    // RUN cycle already carries live data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_BLANK;
            blank_cnt <= BLANK_RELOAD;
            ramp_cnt  <= '0;
            prev_sel  <= '0;
            prev_ch   <= '0;
            pending   <= 1'b0;
            data      <= '0;
            clk_en    <= 1'b0;
        end else begin
            prev_sel <= sel;
            prev_ch  <= ch_sel;
            case (state)
                ST_RUN: begin
                    if (changed) begin
                        state     <= ST_BLANK;
                        blank_cnt <= BLANK_RELOAD;
                        data      <= '0;
                        clk_en    <= 1'b0;
                        if (src == SRC_RAMP) ramp_cnt <= '0;
                    end else if (freeze) begin
                        state  <= ST_FROZEN;
                        clk_en <= 1'b0;
                    end else begin
                        data   <= live_data;
                        clk_en <= live_en;
                        if (src == SRC_RAMP && live_en) ramp_cnt <= ramp_cnt + STEP;
                    end
                end
                ST_BLANK: begin
                    if (changed) begin
                        blank_cnt <= BLANK_RELOAD;
                        data      <= '0;
                        clk_en    <= 1'b0;
                        if (src == SRC_RAMP) ramp_cnt <= '0;
                    end else if (blank_cnt == '0) begin
                        if (freeze) begin
                            state <= ST_FROZEN;
                        end else begin
                            state  <= ST_RUN;
                            data   <= live_data;
                            clk_en <= live_en;
                        end
                    end else begin
                        blank_cnt <= blank_cnt - BLANK_W'(1);
                    end
                end
                ST_FROZEN: begin
                    if (!freeze) begin
                        if (pending || changed) begin
                            state     <= ST_BLANK;
                            blank_cnt <= BLANK_RELOAD;
                            pending   <= 1'b0;
                            data      <= '0;
                            clk_en    <= 1'b0;
                            if (src == SRC_RAMP) ramp_cnt <= '0;
                        end else begin
                            state  <= ST_RUN;
                            data   <= live_data;
                            clk_en <= live_en;
                        end
                    end else begin
                        clk_en <= 1'b0;
                        if (changed) pending <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_BLANK;
                    blank_cnt <= BLANK_RELOAD;
                    data      <= '0;
                    clk_en    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/bitsync_dac_mux_n.sv
// Routes NUM_CH bitsync channels' internal signals to NUM_DAC independent test DACs.
module bitsync_dac_mux_n
    import bitsync_dac_pkg::*;
#(
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned NUM_DAC      = 3,
    parameter int unsigned DATA_W       = 18,
    parameter int unsigned AGC_W        = 21,
    parameter int unsigned LOCK_W       = 16,
    parameter int unsigned BLANK_CYCLES = 4,
    parameter int unsigned RAMP_STEP    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    bitsync_dac_mux_n_if.slave   bus
);

    localparam int unsigned AGC_DROP = AGC_W - DATA_W;

    logic [NUM_CH*DATA_W-1:0]  agc_top;
    logic [NUM_DAC-1:0]        lane_en;
    logic [NUM_DAC*DATA_W-1:0] lane_data;

    // Only the top DATA_W bits of each AGC gain reach the DACs.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_agc
        assign agc_top[c*DATA_W +: DATA_W] = bus.agcGain[c*AGC_W + AGC_W - 1 -: DATA_W];
    end

    if (AGC_DROP > 0) begin : g_agc_lsbs
        logic [NUM_CH*AGC_DROP-1:0] unused_agc_lsbs;
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            assign unused_agc_lsbs[c*AGC_DROP +: AGC_DROP] = bus.agcGain[c*AGC_W +: AGC_DROP];
        end
    end

    for (genvar d = 0; d < NUM_DAC; d++) begin : g_lane
        bitsync_dac_lane #(
            .NUM_CH       (NUM_CH),
            .DATA_W       (DATA_W),
            .LOCK_W       (LOCK_W),
            .BLANK_CYCLES (BLANK_CYCLES),
            .RAMP_STEP    (RAMP_STEP)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .df_data  (bus.dfData),
            .df_en    (bus.dfClkEn),
            .sym_data (bus.symData),
            .sym2x_en (bus.sym2xEn),
            .sym_en   (bus.symEn),
            .agc_data (agc_top),
            .lock_cnt (bus.lockCounter),
            .sel      (bus.dacSelect[d*SEL_W +: SEL_W]),
            .ch_sel   (bus.dacChSel[d*CHSEL_W +: CHSEL_W]),
            .freeze   (bus.dacFreeze[d]),
            .clk_en   (lane_en[d]),
            .data     (lane_data[d*DATA_W +: DATA_W])
        );
    end

    assign bus.dacClkEn = lane_en;
    assign bus.dacData  = lane_data;

endmodule
